// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one sized load/store over a valid/ready
// request channel, waits LATENCY cycles, then returns one response.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_wen           1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_sign          sign-extend byte/half loads
//   req_addr          byte address
//   req_wdata         store data (low lanes used for byte/half)
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data; 0 for stores and errors
//   resp_err          misaligned, illegal size or out of range
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              req_ready_nxt, resp_valid_nxt, resp_err_nxt;
    logic [31:0]       resp_rdata_nxt;

    // Latched request
    logic              lat_wen, lat_sign;
    logic [1:0]        lat_size;
    logic [31:0]       lat_addr, lat_wdata;

    logic              latch_en, commit;

    // Operand seen by the commit logic: live inputs when committing straight
    // out of IDLE (LATENCY=1), otherwise the latched copy.
    logic              op_wen, op_sign, op_err;
    logic [1:0]        op_size;
    logic [31:0]       op_addr, op_wdata;
    logic [AW-1:0]     op_idx;
    logic [31:0]       rd_word, load_val, wlanes;
    logic [3:0]        be;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    logic [31:0] mem [DEPTH_WORDS];

    // Operand selection and access decode
    always_comb begin
        if (state == IDLE) begin
            op_wen   = req_wen;
            op_sign  = req_sign;
            op_size  = req_size;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end else begin
            op_wen   = lat_wen;
            op_sign  = lat_sign;
            op_size  = lat_size;
            op_addr  = lat_addr;
            op_wdata = lat_wdata;
        end

        op_idx = op_addr[AW+1:2];
        op_err = (op_size == 2'b11)
              || (op_size == 2'b01 && op_addr[0])
              || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
              || ((op_addr >> (AW + 2)) != 32'd0);

        rd_word = mem[op_idx];
        rd_byte = 8'(rd_word >> {op_addr[1:0], 3'b000});
        rd_half = 16'(rd_word >> {op_addr[1], 4'b0000});

        case (op_size)
            2'b00:   load_val = {{24{op_sign & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{op_sign & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase

        case (op_size)
            2'b00: begin
                wlanes = {4{op_wdata[7:0]}};
                be     = 4'(4'b0001 << op_addr[1:0]);
            end
            2'b01: begin
                wlanes = {2{op_wdata[15:0]}};
                be     = op_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wlanes = op_wdata;
                be     = 4'b1111;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        latch_en       = 1'b0;
        commit         = 1'b0;
        resp_rdata_nxt = resp_rdata;
        resp_err_nxt   = resp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt      = IDLE;
                    resp_rdata_nxt = 32'd0;
                    resp_err_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (commit) begin
            resp_err_nxt   = op_err;
            resp_rdata_nxt = (op_err || op_wen) ? 32'd0 : load_val;
        end

        req_ready_nxt  = (state_nxt == IDLE);
        resp_valid_nxt = (state_nxt == RESP);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            lat_wen    <= 1'b0;
            lat_sign   <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
            if (latch_en) begin
                lat_wen   <= req_wen;
                lat_sign  <= req_sign;
                lat_size  <= req_size;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
        end
    end

    // Array write; rst guard keeps a same-cycle commit from landing during reset
    always_ff @(posedge clk) begin
        if (commit && !rst && op_wen && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[op_idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LAT     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model_bytes [4*DEPTH];

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian assembly of bytes
    function automatic void model_access(input logic wen, input logic [1:0] size,
                                         input logic sign, input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic err);
        int nb;
        logic [31:0] v;
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err   = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
             || (size == 2'd2 && addr % 4 != 0) || (addr >= 4 * DEPTH);
        rdata = 32'd0;
        if (err) return;
        if (wen) begin
            for (int i = 0; i < nb; i++)
                model_bytes[int'(addr) + i] = 8'(wdata >> (8 * i));
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++)
                v = v | (32'(model_bytes[int'(addr) + i]) << (8 * i));
            if (sign && nb < 4 && v[8*nb-1])
                v = v | ~((32'd1 << (8 * nb)) - 32'd1);
            rdata = v;
        end
    endfunction

    // One full transaction with latency, stability and ready checks
    task automatic xact(input logic wen, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input string name,
                        output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        check({name, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_size   = size;
        req_sign   = sign;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (delay == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 100) begin
            check({name, ".req_ready_busy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check({name, ".latency"}, 32'(n), 32'(LAT));
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({name, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({name, ".hold_rdata"}, resp_rdata, rdata);
            check({name, ".hold_err"}, 32'(resp_err), 32'(err));
            check({name, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check({name, ".valid_drop"}, 32'(resp_valid), 32'd0);
        check({name, ".ready_back"}, 32'(req_ready), 32'd1);
        resp_ready = 1'b0;
    endtask

    function automatic void add_vec(input logic wen, input logic [1:0] size, input logic sign,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] exp_rdata, input logic exp_err,
                                    input string name);
        vec_t v;
        v.wen = wen; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        logic        wen, sign;
        logic [1:0]  size;
        logic [31:0] addr, wdata;

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_sign = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;

        // Known contents for words 0..63
        for (int i = 0; i < 64; i++) begin
            wdata = $urandom;
            model_access(1'b1, 2'd2, 1'b0, 32'(4 * i), wdata, mrd, mer);
            xact(1'b1, 2'd2, 1'b0, 32'(4 * i), wdata, 0, "init", rd, er);
        end

        add_vec(1, 2'd2, 0, 32'h40, 32'h12345678, 32'h0, 0, "st_word_40");
        add_vec(0, 2'd2, 0, 32'h40, 32'h0, 32'h12345678, 0, "ld_word_40");
        add_vec(1, 2'd0, 0, 32'h42, 32'h00000080, 32'h0, 0, "st_byte_42");
        add_vec(0, 2'd0, 1, 32'h42, 32'h0, 32'hFFFFFF80, 0, "ld_byte_s");
        add_vec(0, 2'd0, 0, 32'h42, 32'h0, 32'h00000080, 0, "ld_byte_u");
        add_vec(0, 2'd2, 0, 32'h40, 32'h0, 32'h12805678, 0, "ld_word_merged");
        add_vec(1, 2'd2, 0, 32'h44, 32'hCAFEF00D, 32'h0, 0, "st_word_44");
        add_vec(0, 2'd1, 1, 32'h46, 32'h0, 32'hFFFFCAFE, 0, "ld_half_s");
        add_vec(0, 2'd1, 0, 32'h44, 32'h0, 32'h0000F00D, 0, "ld_half_u");
        add_vec(0, 2'd1, 0, 32'h41, 32'h0, 32'h0, 1, "ld_half_misal");
        add_vec(1, 2'd2, 0, 32'h46, 32'hDEADBEEF, 32'h0, 1, "st_word_misal");
        add_vec(1, 2'd3, 0, 32'h44, 32'h55555555, 32'h0, 1, "st_size11");
        add_vec(0, 2'd3, 0, 32'h44, 32'h0, 32'h0, 1, "ld_size11");
        add_vec(0, 2'd2, 0, 32'h44, 32'h0, 32'hCAFEF00D, 0, "ld_unchanged");
        add_vec(0, 2'd2, 0, 32'h1000, 32'h0, 32'h0, 1, "ld_oor");
        add_vec(1, 2'd1, 0, 32'h46, 32'hFFFFAB12, 32'h0, 0, "st_half_46");
        add_vec(0, 2'd2, 0, 32'h44, 32'h0, 32'hAB12F00D, 0, "ld_word_44");

        foreach (vecs[i]) begin
            model_access(vecs[i].wen, vecs[i].size, vecs[i].sign, vecs[i].addr,
                         vecs[i].wdata, mrd, mer);
            xact(vecs[i].wen, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata,
                 0, vecs[i].name, rd, er);
            check({vecs[i].name, ".rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, ".err"}, 32'(er), 32'(vecs[i].exp_err));
        end

        // Backpressure: response held 3 cycles
        xact(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3, "bp", rd, er);
        check("bp.rdata", rd, 32'h12805678);
        check("bp.err", 32'(er), 32'd0);

        // Reset during BUSY of a store to 0x80
        model_access(1'b1, 2'd2, 1'b0, 32'h80, 32'h11112222, mrd, mer);
        xact(1'b1, 2'd2, 1'b0, 32'h80, 32'h11112222, 0, "pre80", rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_sign = 1'b0;
        req_addr = 32'h80; req_wdata = 32'h99999999;
        @(posedge clk);
        @(negedge clk);
        check("mid.req_ready_busy", 32'(req_ready), 32'd0);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("mid.req_ready", 32'(req_ready), 32'd1);
        check("mid.resp_valid", 32'(resp_valid), 32'd0);
        check("mid.resp_rdata", resp_rdata, 32'd0);
        check("mid.resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid.no_resp", 32'(resp_valid), 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 1, "post80", rd, er);
        check("post80.rdata", rd, 32'h11112222);
        check("post80.err", 32'(er), 32'd0);

        // Random traffic against the byte model
        for (int i = 0; i < 300; i++) begin
            wen   = 1'($urandom);
            size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sign  = 1'($urandom);
            addr  = ($urandom_range(0, 5) == 0) ? 32'h1000 + 32'($urandom_range(0, 15))
                                                : 32'($urandom_range(0, 255));
            wdata = $urandom;
            model_access(wen, size, sign, addr, wdata, mrd, mer);
            xact(wen, size, sign, addr, wdata, $urandom_range(0, 2), "rand", rd, er);
            check("rand.rdata", rd, mrd);
            check("rand.err", 32'(er), 32'(mer));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
